// File: rtl/pixel_arbiter_if.sv
// Pixel arbiter bus: requester-side pixel handshake plus the VGA adapter
// write port and arbiter status. The arbiter connects through the slave
// modport; the requesters/VGA side (or a testbench) through master.
interface pixel_arbiter_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
);
    logic [2:0]      req;
    logic [3*XW-1:0] x_in;
    logic [3*YW-1:0] y_in;
    logic [3*CW-1:0] color_in;
    logic [2:0]      last;
    logic [2:0]      gnt;
    logic            plot;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   color;
    logic            busy;
    logic [1:0]      owner;

    modport master (
        output req, x_in, y_in, color_in, last,
        input  gnt, plot, x, y, color, busy, owner
    );

    modport slave (
        input  req, x_in, y_in, color_in, last,
        output gnt, plot, x, y, color, busy, owner
    );
endinterface

// File: rtl/pixel_arbiter.sv
// Three-way round-robin burst arbiter feeding a VGA adapter write port.
// Requester 0 = sky, 1 = catcher, 2 = score/overlay. A burst holds one owner
// until it delivers a pixel flagged last or drops its request, followed by a
// mandatory one-cycle IDLE turnaround. Accepted pixels are registered onto
// x/y/color with plot one cycle after acceptance.
// Optional feature: define PIXEL_ARB_CLIP_EN to suppress plotting of
// accepted pixels that fall outside X_LIMIT x Y_LIMIT.
module pixel_arbiter #(
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int X_LIMIT = 160,
    parameter int Y_LIMIT = 120
) (
    input logic            clock,
    input logic            reset,
    pixel_arbiter_if.slave bus
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [1:0]    owner_q;
    logic          plot_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] color_q;

    logic [2:0]    gnt_c;
    logic          accept;
    logic          in_range;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [CW-1:0] sel_c;
    logic [1:0]    cand0, cand1, pick;

    // Grant only the owner, and only while its request is up in BURST.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt_c = '0;
        if (state == BURST) begin
            gnt_c[owner_q] = bus.req[owner_q];
        end
    end

    assign accept = (state == BURST) && bus.req[owner_q];

    // Select the owner's pixel fields from the packed request buses.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < 3; i++) begin
            if (owner_q == 2'(i)) begin
                sel_x = bus.x_in[i*XW +: XW];
                sel_y = bus.y_in[i*YW +: YW];
                sel_c = bus.color_in[i*CW +: CW];
            end
        end
    end

    // Round-robin pick starting after the most recent owner; the owner
    // itself is the last candidate so a lone requester can win again.
    always_comb begin
        cand0 = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
        if (bus.req[cand0]) begin
            pick = cand0;
        end else if (bus.req[cand1]) begin
            pick = cand1;
        end else begin
            pick = owner_q;
        end
    end

`ifdef PIXEL_ARB_CLIP_EN
    localparam logic [XW:0] X_LIM = (XW+1)'(X_LIMIT);
    localparam logic [YW:0] Y_LIM = (YW+1)'(Y_LIMIT);
    assign in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
`else
    assign in_range = 1'b1;
`endif

    // Burst FSM plus the registered VGA write port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner_q <= 2'd2;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            plot_q <= 1'b0;
            if (accept && in_range) begin
                plot_q  <= 1'b1;
                x_q     <= sel_x;
                y_q     <= sel_y;
                color_q <= sel_c;
            end
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner_q <= pick;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    if (!bus.req[owner_q] || (accept && bus.last[owner_q])) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_c;
    assign bus.plot  = plot_q;
    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.color = color_q;
    assign bus.busy  = (state == BURST);
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Self-checking bench for pixel_arbiter. A traffic driver presents queued
// pixels per requester; each accepted pixel is pushed to a scoreboard and
// popped when plot appears, which must be exactly one cycle later.
module tb_pixel_arbiter;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
`ifdef PIXEL_ARB_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0]    who;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic          last;
    } pix_t;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        int            cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    pix_t pend[$];
    exp_t exp_q[$];
    int   acc_who[$];
    int   acc_cyc[$];
    int   acc_count = 0;
    int   plot_count = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    pixel_arbiter_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

    pixel_arbiter #(
        .XW(XW), .YW(YW), .CW(CW), .X_LIMIT(160), .Y_LIMIT(120)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    function automatic int find_pend(input int i);
        for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].who == 2'(i)) return j;
        end
        return -1;
    endfunction

    function automatic bit plottable(input logic [XW-1:0] x, input logic [YW-1:0] y);
        if (CLIP_ON) return (x < 8'd160) && (y < 7'd120);
        return 1'b1;
    endfunction

    // Traffic driver: present each requester's oldest pending pixel.
    initial begin
        int k;
        bus.req      = '0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        bus.color_in = '0;
        bus.last     = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 3; i++) begin
                k = find_pend(i);
                if (k >= 0) begin
                    bus.req[i]             = 1'b1;
                    bus.x_in[i*XW +: XW]    = pend[k].x;
                    bus.y_in[i*YW +: YW]    = pend[k].y;
                    bus.color_in[i*CW +: CW] = pend[k].c;
                    bus.last[i]            = pend[k].last;
                end else begin
                    bus.req[i]  = 1'b0;
                    bus.last[i] = 1'b0;
                end
            end
        end
    end

    // Scoreboard check of plots, then record this cycle's acceptance.
    always @(negedge clock) begin
        exp_t e;
        int   k;
        if (bus.plot === 1'b1) begin
            plot_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL plot_unexpected: plot=1 at cycle %0d with no accepted pixel pending", cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.x !== e.x || bus.y !== e.y || bus.color !== e.c || cyc != e.cyc + 1) begin
                    fails++;
                    $display("FAIL plot_pixel: got x=%0d y=%0d c=%b at cycle %0d, want x=%0d y=%0d c=%b at cycle %0d",
                             bus.x, bus.y, bus.color, cyc, e.x, e.y, e.c, e.cyc + 1);
                end
            end
        end
        if (reset === 1'b1 && bus.gnt !== 3'b000) begin
            tests++;
            if ($countones(bus.gnt) != 1 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL gnt_onehot: gnt=%b busy=%b, want one-hot gnt with busy=1", bus.gnt, bus.busy);
            end
        end
        if (reset === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.req[i] === 1'b1 && bus.gnt[i] === 1'b1) begin
                    k = find_pend(i);
                    if (k >= 0) begin
                        acc_who.push_back(i);
                        acc_cyc.push_back(cyc);
                        acc_count++;
                        if (plottable(pend[k].x, pend[k].y)) begin
                            e.x = pend[k].x;
                            e.y = pend[k].y;
                            e.c = pend[k].c;
                            e.cyc = cyc;
                            exp_q.push_back(e);
                        end
                        pend.delete(k);
                    end
                end
            end
        end
    end

    task automatic add_pix(input int who, input int x, input int y, input int c, input bit last);
        pix_t p;
        p.who  = 2'(who);
        p.x    = XW'(x);
        p.y    = YW'(y);
        p.c    = CW'(c);
        p.last = last;
        pend.push_back(p);
    endtask

    task automatic clear_model();
        pend.delete();
        exp_q.delete();
        acc_who.delete();
        acc_cyc.delete();
        acc_count = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        clear_model();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_acc(input int n, input string name);
        int k = 0;
        while (acc_count < n && k < 200) begin
            @(posedge clock);
            k++;
        end
        if (acc_count < n) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d accepted pixels, want %0d", name, acc_count, n);
        end
    endtask

    task automatic wait_cyc(input int t);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (cyc < t && k < 500);
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clock);
        tests++;
        if (exp_q.size() != 0 || pend.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d unplotted, %0d unsent, want 0 and 0", name, exp_q.size(), pend.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #3;
        tests += 7;
        if (bus.gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
        if (bus.plot !== 1'b0) begin fails++; $display("FAIL reset_plot: got %b want 0", bus.plot); end
        if (bus.x !== '0) begin fails++; $display("FAIL reset_x: got %0d want 0", bus.x); end
        if (bus.y !== '0) begin fails++; $display("FAIL reset_y: got %0d want 0", bus.y); end
        if (bus.color !== '0) begin fails++; $display("FAIL reset_color: got %b want 000", bus.color); end
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.owner !== 2'd2) begin fails++; $display("FAIL reset_owner: got %0d want 2", bus.owner); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < 2; p++) add_pix(w, 10 * w + p + 1, w + 1, w + 1, p == 1);
        end
        wait_acc(6, "rr");
        check_drained("rr");
        tests++;
        if (acc_who.size() != 6) begin
            fails++;
            $display("FAIL rr_count: got %0d accepts want 6", acc_who.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                tests++;
                if (acc_who[j] != j / 2) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: got owner %0d want %0d", j, acc_who[j], j / 2);
                end
            end
            for (int j = 1; j < 6; j++) begin
                tests++;
                if (acc_cyc[j] - acc_cyc[j-1] != ((j % 2 == 1) ? 1 : 2)) begin
                    fails++;
                    $display("FAIL rr_gap[%0d]: got %0d cycles want %0d", j, acc_cyc[j] - acc_cyc[j-1], (j % 2 == 1) ? 1 : 2);
                end
            end
        end
    endtask

    task automatic test_single_burst();
        int pc0;
        do_reset();
        pc0 = plot_count;
        for (int i = 0; i < 5; i++) add_pix(1, 10 + i, 20, 3'b100, i == 4);
        wait_acc(5, "single");
        check_drained("single");
        tests++;
        if (plot_count - pc0 != 5) begin
            fails++;
            $display("FAIL single_plots: got %0d want 5", plot_count - pc0);
        end
        for (int j = 1; j < acc_cyc.size(); j++) begin
            tests++;
            if (acc_cyc[j] - acc_cyc[j-1] != 1) begin
                fails++;
                $display("FAIL single_rate[%0d]: got gap %0d want 1", j, acc_cyc[j] - acc_cyc[j-1]);
            end
        end
        tests++;
        if (bus.plot !== 1'b0 || bus.x !== 8'd14 || bus.y !== 7'd20 || bus.color !== 3'b100) begin
            fails++;
            $display("FAIL single_hold: got plot=%b x=%0d y=%0d c=%b want 0 14 20 100", bus.plot, bus.x, bus.y, bus.color);
        end
    endtask

    task automatic test_drop_req();
        int t;
        do_reset();
        for (int i = 0; i < 3; i++) add_pix(0, 40 + i, 5, 3'b001, 1'b0);
        add_pix(2, 90, 9, 3'b111, 1'b1);
        wait_acc(3, "drop");
        if (acc_cyc.size() >= 3) begin
            t = acc_cyc[2];
            wait_cyc(t + 1);
            tests++;
            if (bus.busy !== 1'b1 || bus.gnt !== 3'b000) begin
                fails++;
                $display("FAIL drop_c1: got busy=%b gnt=%b want 1 000", bus.busy, bus.gnt);
            end
            wait_cyc(t + 2);
            tests++;
            if (bus.busy !== 1'b0 || bus.gnt !== 3'b000) begin
                fails++;
                $display("FAIL drop_idle: got busy=%b gnt=%b want 0 000", bus.busy, bus.gnt);
            end
            wait_cyc(t + 3);
            tests++;
            if (bus.owner !== 2'd2 || bus.gnt !== 3'b100 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL drop_next: got owner=%0d gnt=%b busy=%b want 2 100 1", bus.owner, bus.gnt, bus.busy);
            end
        end
        wait_acc(4, "drop2");
        check_drained("drop");
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_pix(0, 1, 1, 3'b010, 1'b1);
        add_pix(0, 2, 2, 3'b011, 1'b1);
        wait_acc(2, "b2b");
        check_drained("b2b");
        tests++;
        if (acc_who.size() != 2 || acc_who[0] != 0 || acc_who[1] != 0 || acc_cyc[1] - acc_cyc[0] != 2) begin
            fails++;
            $display("FAIL b2b_turnaround: got %0d accepts, gap %0d, want 2 accepts by owner 0 with gap 2",
                     acc_who.size(), (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        do_reset();
        for (int i = 0; i < 5; i++) add_pix(1, 60 + i, 30, 3'b110, i == 4);
        wait_acc(2, "rst");
        if (acc_cyc.size() >= 2) begin
            t = acc_cyc[1];
            wait_cyc(t + 1);
            tests++;
            if (bus.gnt !== 3'b010 || bus.plot !== 1'b1) begin
                fails++;
                $display("FAIL rst_third: got gnt=%b plot=%b want 010 1", bus.gnt, bus.plot);
            end
            #2;
            reset = 1'b0;
            #1;
            tests++;
            if (bus.plot !== 1'b0 || bus.gnt !== 3'b000 || bus.owner !== 2'd2 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL rst_abort: got plot=%b gnt=%b owner=%0d busy=%b want 0 000 2 0",
                         bus.plot, bus.gnt, bus.owner, bus.busy);
            end
            clear_model();
            repeat (2) @(negedge clock);
            reset = 1'b1;
        end
        add_pix(1, 70, 31, 3'b101, 1'b1);
        wait_acc(1, "rst_regrant");
        check_drained("rst");
        tests++;
        if (acc_who.size() != 1 || acc_who[0] != 1) begin
            fails++;
            $display("FAIL rst_regrant: got %0d accepts, want one by requester 1", acc_who.size());
        end
    endtask

    task automatic test_clip();
        int pc0;
        int want_plots;
        logic [XW-1:0] want_x;
        do_reset();
        pc0 = plot_count;
        add_pix(0, 159, 0, 3'b001, 1'b0);
        add_pix(0, 160, 0, 3'b010, 1'b1);
        wait_acc(2, "clip");
        check_drained("clip");
        want_plots = CLIP_ON ? 1 : 2;
        want_x = CLIP_ON ? 8'd159 : 8'd160;
        tests++;
        if (plot_count - pc0 != want_plots) begin
            fails++;
            $display("FAIL clip_plots: got %0d want %0d", plot_count - pc0, want_plots);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.x !== want_x) begin
            fails++;
            $display("FAIL clip_end: got busy=%b x=%0d want 0 %0d", bus.busy, bus.x, want_x);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_burst();
        test_drop_req();
        test_back_to_back();
        test_reset_mid_burst();
        test_clip();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
